counter_updown_mod: RTL and testbench
=====================================

# counter_updown_mod

Parametrised synchronous up/down counter with modulus, wrap or saturate mode, synchronous clear, parallel load with clamping, and cascade-ready terminal-count output. It is the general counting primitive for the lab designs, and it replaces fixed 4-bit counters in timers, address generators and BCD/modulo chains. It instantiates directly as a decade (MAX_VAL=9) or any 0..MAX_VAL counter, and it cascades through Tc.

## Interface
- WIDTH, 8, counter width in bits (≥2)
- MAX_VAL, 2**WIDTH-1, upper count bound; range is 0..MAX_VAL; must be ≤ 2**WIDTH-1
- clk  input  1  rising-edge clock
- nReset  input  1  reset, asynchronous, active-low
- Clear  input  1  synchronous clear to 0
- Load  input  1  synchronous parallel load of Count_in
- Count_en  input  1  count enable
- Up  input  1  1 = count up, 0 = count down
- Sat_mode  input  1  1 = saturate at bounds, 0 = wrap modulo MAX_VAL+1
- Count_in  input  WIDTH  parallel load value
- Count_out  output  WIDTH  current count (registered)
- Tc  output  1  terminal count, combinational, for cascading
- Wrap  output  1  registered one-cycle pulse, wrap occurred
- At_bound  output  1  registered level, count is held at a bound in saturate mode
- Cmp_val  input  WIDTH  compare value (only with COUNTER_CMP_EN)
- Cmp_match  output  1  registered compare flag (only with COUNTER_CMP_EN)

## Operation
- Priority per edge: nReset > Clear > Load > Count_en > hold.
- Clear: Count_out←0; Wrap←0; At_bound←0.
- Load: Count_out←min(Count_in, MAX_VAL). An out-of-range value clamps and does not raise Wrap. Wrap←0.
- Count up, not at MAX_VAL: Count_out+1.
- Count up, at MAX_VAL:
  - wrap mode: Count_out←0, Wrap←1
  - saturate mode: hold at MAX_VAL, At_bound←1
- Count down, not at 0: Count_out−1.
- Count down, at 0:
  - wrap mode: Count_out←MAX_VAL, Wrap←1
  - saturate mode: hold at 0, At_bound←1
- Wrap is 1 only for the cycle following a wrapping edge. Otherwise it is 0.
- At_bound clears on any edge that moves the count off the bound, and on Clear/Load.
- Tc = Count_en & ~Load & ~Clear & (Up ? Count_out==MAX_VAL : Count_out==0). Tc is asserted in both modes. A downstream stage uses Tc as its Count_en.
- Sat_mode and Up may change on any cycle. They take effect at the next edge, with no internal state.
- All arithmetic is done in WIDTH+1 bits internally. No reliance on native 2**WIDTH overflow when MAX_VAL < 2**WIDTH-1.

## Timing
- Reset (async assert, sync release on the next clk after deassert): Count_out=0, Wrap=0, At_bound=0, Cmp_match=0.
- Reset asserted mid-count forces the outputs to 0 immediately, without waiting for clk.
- Latency is 1 clk from a control input to Count_out, Wrap, At_bound and Cmp_match.
- Tc has 0-cycle combinational latency from Count_out and the control inputs. It contains no path from Count_in.
- Simultaneous Clear+Load+Count_en: Clear wins. Load+Count_en: Load wins, no count.

## Configuration
- COUNTER_CMP_EN defined:
  - adds Cmp_val and Cmp_match
  - Cmp_match←(next Count_out == Cmp_val), registered, so it is high in the same cycle Count_out equals Cmp_val
  - Cmp_match is 0 on reset
- COUNTER_CMP_EN undefined: the ports and logic are absent. Behaviour is otherwise identical.

## Structure
- Package counter_pkg:
  - typedef enum for count direction (CNT_DOWN, CNT_UP)
  - typedef enum for bound mode (BND_WRAP, BND_SAT)
  - function clamp(value, max)
- Sub-module counter_next_val: combinational next-count, wrap and at-bound computation. The top holds only the registers and the priority mux.

## Test plan
- WIDTH=4, MAX_VAL=9, wrap, Up=1, Count_en=1 from 0 -> sequence 0..9,0; Wrap=1 in the cycle after 9→0; Tc=1 while Count_out=9.
- Same config, Up=0 from 0 -> 9,8,…; Wrap pulse after 0→9.
- Sat_mode=1, Load Count_in=7, count up 5 cycles -> 8,9,9,9,9; At_bound=1 from the second 9 on; no Wrap pulse; then Up=0 -> 8, At_bound=0.
- Load Count_in=4'hF with MAX_VAL=9 -> Count_out=9. Clear+Load+Count_en together -> Count_out=0.
- nReset pulsed low between edges at Count_out=5 -> Count_out=0 immediately, then counting resumes one edge after release.
- COUNTER_CMP_EN, Cmp_val=3, count up from 0 -> Cmp_match=1 exactly while Count_out=3.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and helpers for the up/down counter family.
package counter_pkg;

  typedef enum logic {CNT_DOWN = 1'b0, CNT_UP  = 1'b1} cnt_dir_e;
  typedef enum logic {BND_WRAP = 1'b0, BND_SAT = 1'b1} bnd_mode_e;

  function automatic logic [31:0] clamp(input logic [31:0] value, input logic [31:0] max);
    return (value > max) ? max : value;
  endfunction

endpackage

// File: rtl/counter_next_val.sv
// Combinational next count for one counting edge: step, wrap or saturate at 0/MAX_VAL.
module counter_next_val
  import counter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_VAL = 2**WIDTH-1
) (
  input  logic [WIDTH-1:0] count_i,
  input  cnt_dir_e         dir_i,
  input  bnd_mode_e        mode_i,
  output logic [WIDTH-1:0] next_o,
  output logic             wrap_o,
  output logic             at_bound_o
);

  // Extra bit keeps MAX_VAL+1 representable, so a non-power-of-two modulus never relies on overflow.
  localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MAX_VAL);

  logic [WIDTH:0] cnt_ext;
  logic [WIDTH:0] nxt_ext;
  logic           unused_msb;

  assign cnt_ext = {1'b0, count_i};

  always_comb begin
    nxt_ext    = cnt_ext;
    wrap_o     = 1'b0;
    at_bound_o = 1'b0;
    if (dir_i == CNT_UP) begin
      if (cnt_ext >= MAX_EXT) begin
        if (mode_i == BND_SAT) begin
          nxt_ext    = MAX_EXT;
          at_bound_o = 1'b1;
        end else begin
          nxt_ext = '0;
          wrap_o  = 1'b1;
        end
      end else begin
        nxt_ext = cnt_ext + 1'b1;
      end
    end else begin
      if (cnt_ext == '0) begin
        if (mode_i == BND_SAT) begin
          at_bound_o = 1'b1;
        end else begin
          nxt_ext = MAX_EXT;
          wrap_o  = 1'b1;
        end
      end else begin
        nxt_ext = cnt_ext - 1'b1;
      end
    end
  end

  assign next_o     = nxt_ext[WIDTH-1:0];
  assign unused_msb = nxt_ext[WIDTH];

endmodule

// File: rtl/counter_updown_mod.sv
// Up/down 0..MAX_VAL counter: clear, clamped load, wrap/saturate, cascade Tc.
// Define COUNTER_CMP_EN to add the registered compare flag (Cmp_val/Cmp_match).
module counter_updown_mod
  import counter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_VAL = 2**WIDTH-1
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             Clear,
  input  logic             Load,
  input  logic             Count_en,
  input  logic             Up,
  input  logic             Sat_mode,
  input  logic [WIDTH-1:0] Count_in,
  output logic [WIDTH-1:0] Count_out,
  output logic             Tc,
  output logic             Wrap,
  output logic             At_bound
`ifdef COUNTER_CMP_EN
  ,
  input  logic [WIDTH-1:0] Cmp_val,
  output logic             Cmp_match
`endif
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             at_bound_q, at_bound_d;
  logic [WIDTH-1:0] nv_cnt;
  logic             nv_wrap;
  logic             nv_at_bound;
  logic [WIDTH-1:0] load_val;
  cnt_dir_e         dir;
  bnd_mode_e        mode;

  assign dir      = cnt_dir_e'(Up);
  assign mode     = bnd_mode_e'(Sat_mode);
  assign load_val = WIDTH'(clamp(32'(Count_in), 32'(MAX_VAL)));

  counter_next_val #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) u_next (
    .count_i    (cnt_q),
    .dir_i      (dir),
    .mode_i     (mode),
    .next_o     (nv_cnt),
    .wrap_o     (nv_wrap),
    .at_bound_o (nv_at_bound)
  );

  always_comb begin
    cnt_d      = cnt_q;
    wrap_d     = 1'b0;
    at_bound_d = at_bound_q;
    if (Clear) begin
      cnt_d      = '0;
      at_bound_d = 1'b0;
    end else if (Load) begin
      cnt_d      = load_val;
      at_bound_d = 1'b0;
    end else if (Count_en) begin
      cnt_d      = nv_cnt;
      wrap_d     = nv_wrap;
      at_bound_d = nv_at_bound;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      cnt_q      <= '0;
      wrap_q     <= 1'b0;
      at_bound_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      wrap_q     <= wrap_d;
      at_bound_q <= at_bound_d;
    end
  end

  // Tc must not see Count_in, so it looks at the current count rather than cnt_d.
  assign Tc = Count_en & ~Load & ~Clear &
              (Up ? (cnt_q == WIDTH'(MAX_VAL)) : (cnt_q == '0));

  assign Count_out = cnt_q;
  assign Wrap      = wrap_q;
  assign At_bound  = at_bound_q;

`ifdef COUNTER_CMP_EN
  logic cmp_q;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) cmp_q <= 1'b0;
    else         cmp_q <= (cnt_d == Cmp_val);
  end

  assign Cmp_match = cmp_q;
`endif

endmodule

// File: tb/tb_counter_updown_mod.sv
// Scoreboard bench for counter_updown_mod at WIDTH=4, MAX_VAL=9 (decade counter).
module tb_counter_updown_mod;

  localparam int W  = 4;
  localparam int MV = 9;

  logic         clk = 1'b0;
  logic         nReset, Clear, Load, Count_en, Up, Sat_mode;
  logic [W-1:0] Count_in;
  logic [W-1:0] Count_out;
  logic         Tc, Wrap, At_bound;
`ifdef COUNTER_CMP_EN
  logic [W-1:0] Cmp_val;
  logic         Cmp_match;
`endif

  typedef struct {
    logic [W-1:0] cnt;
    logic         wrap;
    logic         atb;
    logic         cmp;
  } exp_t;

  exp_t         sb_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] m_cnt;
  logic         m_atb;
  logic [W-1:0] m_cmp_val = 4'd3;

  always #5 clk = ~clk;

  counter_updown_mod #(.WIDTH(W), .MAX_VAL(MV)) dut (
    .clk       (clk),
    .nReset    (nReset),
    .Clear     (Clear),
    .Load      (Load),
    .Count_en  (Count_en),
    .Up        (Up),
    .Sat_mode  (Sat_mode),
    .Count_in  (Count_in),
    .Count_out (Count_out),
    .Tc        (Tc),
    .Wrap      (Wrap),
    .At_bound  (At_bound)
`ifdef COUNTER_CMP_EN
    ,
    .Cmp_val   (Cmp_val),
    .Cmp_match (Cmp_match)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference behaviour of one clock edge, written straight from the counter's rules.
  function automatic exp_t model_edge(input logic clr, ld, en, up, sat, input logic [W-1:0] din);
    exp_t e;
    e.cnt  = m_cnt;
    e.wrap = 1'b0;
    e.atb  = m_atb;
    if (clr) begin
      e.cnt = '0; e.atb = 1'b0;
    end else if (ld) begin
      e.cnt = (din > MV) ? W'(MV) : din; e.atb = 1'b0;
    end else if (en) begin
      e.atb = 1'b0;
      if (up) begin
        if (m_cnt == MV) begin
          if (sat) e.atb = 1'b1;
          else begin e.cnt = '0; e.wrap = 1'b1; end
        end else e.cnt = m_cnt + 1'b1;
      end else begin
        if (m_cnt == 0) begin
          if (sat) e.atb = 1'b1;
          else begin e.cnt = W'(MV); e.wrap = 1'b1; end
        end else e.cnt = m_cnt - 1'b1;
      end
    end
    e.cmp = (e.cnt == m_cmp_val);
    return e;
  endfunction

  task automatic step(input logic clr, ld, en, up, sat, input logic [W-1:0] din);
    exp_t e;
    logic exp_tc;
    Clear = clr; Load = ld; Count_en = en; Up = up; Sat_mode = sat; Count_in = din;
    #1;
    exp_tc = en & ~ld & ~clr & (up ? (m_cnt == MV) : (m_cnt == 0));
    chk("tc", Tc, exp_tc);
    sb_q.push_back(model_edge(clr, ld, en, up, sat, din));
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("count", Count_out, e.cnt);
    chk("wrap", Wrap, e.wrap);
    chk("at_bound", At_bound, e.atb);
`ifdef COUNTER_CMP_EN
    chk("cmp_match", Cmp_match, e.cmp);
`endif
    m_cnt = e.cnt;
    m_atb = e.atb;
  endtask

  initial begin
    nReset = 1'b0; Clear = 1'b0; Load = 1'b0; Count_en = 1'b0;
    Up = 1'b1; Sat_mode = 1'b0; Count_in = '0;
`ifdef COUNTER_CMP_EN
    Cmp_val = m_cmp_val;
`endif
    m_cnt = '0; m_atb = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_count", Count_out, 0);
    chk("rst_wrap", Wrap, 0);
    chk("rst_at_bound", At_bound, 0);
`ifdef COUNTER_CMP_EN
    chk("rst_cmp", Cmp_match, 0);
`endif
    nReset = 1'b1;
    @(posedge clk); #1;

    // wrap mode up 0..9,0 then one more
    for (int i = 0; i < 11; i++) step(0, 0, 1, 1, 0, '0);
    chk("up_final", Count_out, 1);

    // wrap mode down from 0
    step(1, 0, 0, 1, 0, '0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, '0);
    chk("down_final", Count_out, 6);

    // saturate up from 7, then reverse
    step(0, 1, 0, 1, 1, 4'd7);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 1, '0);
    chk("sat_hi", Count_out, 9);
    chk("sat_hi_atb", At_bound, 1);
    step(0, 0, 0, 1, 1, '0);
    chk("hold_keeps_atb", At_bound, 1);
    step(0, 0, 1, 0, 1, '0);
    chk("sat_off_bound", Count_out, 8);

    // saturate down to 0
    step(0, 1, 0, 0, 1, 4'd1);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 1, '0);
    chk("sat_lo", Count_out, 0);

    // load clamping and priorities
    step(0, 1, 0, 1, 0, 4'hF);
    chk("load_clamp", Count_out, 9);
    step(1, 1, 1, 1, 0, 4'd5);
    chk("clear_wins", Count_out, 0);
    step(0, 1, 1, 1, 0, 4'd5);
    chk("load_wins", Count_out, 5);

    // asynchronous reset between edges at count 5
    #2 nReset = 1'b0;
    #1;
    chk("async_rst_count", Count_out, 0);
    chk("async_rst_wrap", Wrap, 0);
    m_cnt = '0; m_atb = 1'b0;
    #1 nReset = 1'b1;
    step(0, 0, 1, 1, 0, '0);
    chk("resume", Count_out, 1);

    // random mix
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0), $urandom_range(0, 3) != 0,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
